// File: rtl/mem_pkg.sv
// Shared encodings for the stack memory unit: stack operation codes and
// write field-select values.
package mem_pkg;

  // spOp encodings, qualified by Esp
  localparam logic [1:0] SP_NOP  = 2'b00;
  localparam logic [1:0] SP_PUSH = 2'b01;
  localparam logic [1:0] SP_POP  = 2'b10;
  localparam logic [1:0] SP_RST  = 2'b11;

  // Edata field select for WE
  localparam logic FIELD_OPCODE = 1'b0;
  localparam logic FIELD_DATA   = 1'b1;

endpackage : mem_pkg

// File: rtl/stack_ctrl.sv
// Stack pointer controller: sp register, occupancy counter, full/empty decode,
// sticky overflow/underflow flags, and the RAM address/enables for push/pop.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   Esp, spOp         stack strobe and operation code
//   sp                current stack pointer (next free slot)
//   stackAddr_c       RAM address for the accepted push (sp) or pop (sp+1)
//   pushEn_c/popEn_c  accepted push / pop this cycle
//   stackOp_c         any non-nop stack op this cycle (blocks WE/Eram)
//   ovf, udf          sticky overflow / underflow
module stack_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Esp,
  input  logic [1:0]        spOp,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] stackAddr_c,
  output logic              pushEn_c,
  output logic              popEn_c,
  output logic              stackOp_c,
  output logic              ovf,
  output logic              udf
);

  // One extra bit so a stack spanning the whole RAM can report full
  localparam int unsigned OCC_W = ADDR_W + 1;

  logic [OCC_W-1:0] occ;
  logic             full;
  logic             empty;

  // Full/empty decode and accepted-operation enables
  always_comb begin
    stackOp_c   = 1'b0;
    full        = 1'b0;
    empty       = 1'b0;
    pushEn_c    = 1'b0;
    popEn_c     = 1'b0;
    stackAddr_c = sp;

    stackOp_c = Esp && (spOp != SP_NOP);
    full      = (occ == OCC_W'(STACK_DEPTH));
    empty     = (occ == OCC_W'(0));
    pushEn_c  = !rst && Esp && (spOp == SP_PUSH) && !full;
    popEn_c   = !rst && Esp && (spOp == SP_POP) && !empty;
    if (popEn_c) begin
      stackAddr_c = sp + ADDR_W'(1);
    end
  end

  // Stack pointer, occupancy and sticky fault flags
  always_ff @(posedge clk) begin
    if (rst) begin
      sp  <= '1;
      occ <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (Esp) begin
      case (spOp)
        SP_PUSH: begin
          if (full) begin
            ovf <= 1'b1;
          end else begin
            sp  <= sp - ADDR_W'(1);
            occ <= occ + OCC_W'(1);
          end
        end
        SP_POP: begin
          if (empty) begin
            udf <= 1'b1;
          end else begin
            sp  <= sp + ADDR_W'(1);
            occ <= occ - OCC_W'(1);
          end
        end
        SP_RST: begin
          sp  <= '1;
          occ <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule : stack_ctrl

// File: rtl/stack_mem_unit.sv
// Single-port word RAM with MAR, hardware stack, registered split
// opcode/data read-out and sticky stack-fault flags.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   Laddr, addrIn         MAR load
//   Eram                  read mem[MAR] into opcodeOut/dataOut
//   WE, Edata, ramIn      field write to mem[MAR] (Edata=1 data, 0 opcode)
//   Esp, spOp             stack op (nop/push/pop/sp reset); beats WE/Eram
//   opcodeOut, dataOut    registered read data
//   rdValid               one-cycle pulse per accepted read or pop
//   sp, ovf, udf          stack pointer and sticky fault flags
module stack_mem_unit
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Laddr,
  input  logic [ADDR_W-1:0] addrIn,
  input  logic              Eram,
  input  logic              WE,
  input  logic              Edata,
  input  logic [DATA_W-1:0] ramIn,
  input  logic              Esp,
  input  logic [1:0]        spOp,
  output logic [DATA_W-1:0] opcodeOut,
  output logic [DATA_W-1:0] dataOut,
  output logic              rdValid,
  output logic [ADDR_W-1:0] sp,
  output logic              ovf,
  output logic              udf
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned WORD_W = 2 * DATA_W;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] mar;
  logic [ADDR_W-1:0] stackAddr_c;
  logic              pushEn_c;
  logic              popEn_c;
  logic              stackOp_c;
  logic              ramWrEn;
  logic              ramRdEn;

  stack_ctrl #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) uStackCtrl (
    .clk         (clk),
    .rst         (rst),
    .Esp         (Esp),
    .spOp        (spOp),
    .sp          (sp),
    .stackAddr_c (stackAddr_c),
    .pushEn_c    (pushEn_c),
    .popEn_c     (popEn_c),
    .stackOp_c   (stackOp_c),
    .ovf         (ovf),
    .udf         (udf)
  );

  // Any active stack op suppresses MAR-based reads and writes
  always_comb begin
    ramWrEn = 1'b0;
    ramRdEn = 1'b0;
    ramWrEn = !rst && WE && !stackOp_c;
    ramRdEn = Eram && !stackOp_c;
  end

  // Memory address register
  always_ff @(posedge clk) begin
    if (rst) begin
      mar <= '0;
    end else if (Laddr) begin
      mar <= addrIn;
    end
  end

  // RAM array, not reset; push writes a full word with the opcode field cleared
  always_ff @(posedge clk) begin
    if (pushEn_c) begin
      mem[stackAddr_c] <= {DATA_W'(0), ramIn};
    end else if (ramWrEn) begin
      if (Edata == FIELD_DATA) begin
        mem[mar][DATA_W-1:0] <= ramIn;
      end else begin
        mem[mar][WORD_W-1:DATA_W] <= ramIn;
      end
    end
  end

  // Registered read-out; reads see the pre-write word of the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      opcodeOut <= '0;
      dataOut   <= '0;
      rdValid   <= 1'b0;
    end else begin
      rdValid <= 1'b0;
      if (popEn_c) begin
        dataOut <= mem[stackAddr_c][DATA_W-1:0];
        rdValid <= 1'b1;
      end else if (ramRdEn) begin
        opcodeOut <= mem[mar][WORD_W-1:DATA_W];
        dataOut   <= mem[mar][DATA_W-1:0];
        rdValid   <= 1'b1;
      end
    end
  end

endmodule : stack_mem_unit

// File: tb/tb_stack_mem_unit.sv
// Scoreboard bench for stack_mem_unit: expected {opcode,data} pushed at issue,
// popped and compared by a monitor whenever rdValid is seen.
module tb_stack_mem_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       Laddr;
  logic [3:0] addrIn;
  logic       Eram;
  logic       WE;
  logic       Edata;
  logic [3:0] ramIn;
  logic       Esp;
  logic [1:0] spOp;
  logic [3:0] opcodeOut;
  logic [3:0] dataOut;
  logic       rdValid;
  logic [3:0] sp;
  logic       ovf;
  logic       udf;

  int checkCnt = 0;
  int passCnt  = 0;
  logic [7:0] expQ [$];

  stack_mem_unit #(.DATA_W(4), .ADDR_W(4), .STACK_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .Laddr     (Laddr),
    .addrIn    (addrIn),
    .Eram      (Eram),
    .WE        (WE),
    .Edata     (Edata),
    .ramIn     (ramIn),
    .Esp       (Esp),
    .spOp      (spOp),
    .opcodeOut (opcodeOut),
    .dataOut   (dataOut),
    .rdValid   (rdValid),
    .sp        (sp),
    .ovf       (ovf),
    .udf       (udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every rdValid pulse must match the oldest expected read
  always @(negedge clk) begin
    if (rdValid === 1'b1) begin
      if (expQ.size() == 0) begin
        check("unexpected_rdValid", {opcodeOut, dataOut}, 8'hxx);
      end else begin
        check("read_data", {opcodeOut, dataOut}, expQ.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rst = 1'b0; Laddr = 1'b0; Eram = 1'b0; WE = 1'b0; Edata = 1'b0;
    Esp = 1'b0; spOp = 2'b00;
  endtask

  task automatic push(input logic [3:0] v);
    Esp = 1'b1; spOp = 2'b01; ramIn = v;
    tick();
  endtask

  task automatic popExp(input logic [3:0] op, input logic [3:0] d);
    Esp = 1'b1; spOp = 2'b10;
    expQ.push_back({op, d});
    tick();
  endtask

  task automatic readExp(input logic [3:0] op, input logic [3:0] d);
    Eram = 1'b1;
    expQ.push_back({op, d});
    tick();
  endtask

  initial begin
    rst = 1'b1; Laddr = 1'b0; addrIn = '0; Eram = 1'b0; WE = 1'b0;
    Edata = 1'b0; ramIn = '0; Esp = 1'b0; spOp = 2'b00;
    rst = 1'b1; tick();
    rst = 1'b1; tick();

    // Reset state
    check("rst_sp", 8'(sp), 8'h0F);
    check("rst_flags", {6'd0, ovf, udf}, 8'h00);
    check("rst_out", {opcodeOut, dataOut}, 8'h00);
    check("rst_rdValid", 8'(rdValid), 8'h00);

    // MAR load and field writes
    Laddr = 1'b1; addrIn = 4'b0001; tick();
    WE = 1'b1; Edata = 1'b0; ramIn = 4'b1010; tick();
    WE = 1'b1; Edata = 1'b1; ramIn = 4'b0111; tick();
    readExp(4'b1010, 4'b0111);
    // Read-before-write
    WE = 1'b1; Edata = 1'b1; ramIn = 4'b0001;
    readExp(4'b1010, 4'b0111);
    readExp(4'b1010, 4'b0001);

    // LIFO
    push(4'b1111);
    push(4'b1110);
    check("lifo_sp2", 8'(sp), 8'h0D);
    popExp(4'b1010, 4'b1110);
    popExp(4'b1010, 4'b1111);
    check("lifo_sp0", 8'(sp), 8'h0F);

    // Overflow
    push(4'd1); push(4'd2); push(4'd3); push(4'd4);
    check("full_ovf_clear", 8'(ovf), 8'h00);
    push(4'd5);
    check("ovf_sp", 8'(sp), 8'h0B);
    check("ovf_flag", 8'(ovf), 8'h01);
    popExp(4'b1010, 4'd4);
    popExp(4'b1010, 4'd3);
    popExp(4'b1010, 4'd2);
    popExp(4'b1010, 4'd1);
    check("ovf_drain_sp", 8'(sp), 8'h0F);

    // Back-to-back push/pop
    push(4'b0110);
    popExp(4'b1010, 4'b0110);

    // Underflow: no rdValid, outputs hold
    Esp = 1'b1; spOp = 2'b10; tick();
    check("udf_flag", 8'(udf), 8'h01);
    check("udf_hold", {opcodeOut, dataOut}, 8'hA6);
    check("udf_rdValid", 8'(rdValid), 8'h00);

    // SP reset keeps sticky flags
    push(4'b0011);
    check("pre_sprst_sp", 8'(sp), 8'h0E);
    Esp = 1'b1; spOp = 2'b11; tick();
    check("sprst_sp", 8'(sp), 8'h0F);
    check("sprst_flags", {6'd0, ovf, udf}, 8'h03);

    // Priority: push beats WE/Eram
    Esp = 1'b1; spOp = 2'b01; ramIn = 4'b1000;
    WE = 1'b1; Edata = 1'b0; Eram = 1'b1; tick();
    check("prio_sp", 8'(sp), 8'h0E);
    check("prio_rdValid", 8'(rdValid), 8'h00);
    readExp(4'b1010, 4'b0001);
    // Laddr with Eram reads the old MAR
    Laddr = 1'b1; addrIn = 4'b1111;
    readExp(4'b1010, 4'b0001);
    readExp(4'b0000, 4'b1000);

    // Reset mid-operation discards a push
    rst = 1'b1; Esp = 1'b1; spOp = 2'b01; ramIn = 4'b1001; tick();
    check("midrst_sp", 8'(sp), 8'h0F);
    check("midrst_out", {opcodeOut, dataOut}, 8'h00);
    check("midrst_flags", {6'd0, ovf, udf}, 8'h00);
    check("midrst_rdValid", 8'(rdValid), 8'h00);
    Laddr = 1'b1; addrIn = 4'b1110; tick();
    readExp(4'b0000, 4'b0010);

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 10 && expQ.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("scoreboard_drained", 8'(expQ.size()), 8'h00);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_stack_mem_unit

// File: doc/stack_mem_unit.md
# stack_mem_unit

Parametrised successor to the CPU's 4-bit memory block: a single-port word RAM with a memory address register (MAR), a hardware stack pointer with push/pop/reset operations, registered split opcode/operand read-out, and sticky stack-fault flags. It sits between the control unit and the datapath bus. Word width, depth and stack region size are parameters. Overflow and underflow are detected, and the block defines priority for simultaneous control strobes.

## Interface
- DATA_W, 4: field width; each RAM word is {opcode field, data field}, 2*DATA_W bits
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W words
- STACK_DEPTH, 4: stack region size in words, occupying addresses DEPTH-STACK_DEPTH .. DEPTH-1; legal range 1..DEPTH

- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- Laddr  in  1  load MAR from addrIn
- addrIn  in  ADDR_W  address for MAR load
- Eram  in  1  read request: mem[MAR] to opcodeOut/dataOut
- WE  in  1  write request: ramIn to one field of mem[MAR]
- Edata  in  1  field select for WE: 1 = data field, 0 = opcode field
- ramIn  in  DATA_W  write data, for both WE and push
- Esp  in  1  stack operation strobe
- spOp  in  2  00 nop, 01 push, 10 pop, 11 SP reset
- opcodeOut  out  DATA_W  registered opcode field
- dataOut  out  DATA_W  registered data field, or popped value
- rdValid  out  1  one-cycle pulse: outputs updated this cycle
- sp  out  ADDR_W  current stack pointer (next free slot)
- ovf  out  1  sticky stack overflow
- udf  out  1  sticky stack underflow

## Operation
- Reset: MAR=0, sp=DEPTH-1, opcodeOut=0, dataOut=0, rdValid=0, ovf=0, udf=0. RAM contents are not cleared.
- Laddr: MAR <= addrIn. MAR is used by every other operation in the same cycle with its old value.
- Eram, with no stack op: {opcodeOut,dataOut} <= mem[MAR]; rdValid=1.
- WE, with no stack op: Edata=1 writes mem[MAR][DATA_W-1:0]; Edata=0 writes the upper field. The other field is preserved.
- WE and Eram together: the read returns the pre-write word (read-before-write).
- Stack is empty when sp==DEPTH-1 and full when sp==DEPTH-1-STACK_DEPTH (mod DEPTH). An occupancy counter is used so that STACK_DEPTH==DEPTH is distinguishable.
- Push (Esp, 01), not full: mem[sp] data field <= ramIn, upper field <= 0; sp <= sp-1.
- Push when full: no write, sp holds, ovf <= 1.
- Pop (Esp, 10), not empty: dataOut <= mem[sp+1] data field; sp <= sp+1; rdValid=1; opcodeOut holds.
- Pop when empty: sp holds, outputs hold, rdValid=0, udf <= 1.
- SP reset (Esp, 11): sp <= DEPTH-1, occupancy cleared. ovf and udf are unchanged; only rst clears them.
- Priority:
  - rst beats everything.
  - Esp with spOp≠00 beats WE/Eram, which are ignored that cycle.
  - Laddr always acts.
- All address arithmetic is modulo DEPTH, ADDR_W bits, unsigned.

## Timing
- Read latency 1 cycle: strobe sampled at edge N, data and rdValid visible after edge N.
- rdValid is high for exactly one cycle per accepted read or pop.
- Write is visible to a read issued in the next cycle.
- Back-to-back push/pop every cycle is supported. A pop directly after a push returns the pushed value.
- Outputs hold their values between reads.
- rst asserted mid-sequence takes effect at the next edge. A push in that cycle is discarded and does not write RAM.

## Structure
- Shared package `mem_pkg`: spOp encodings (SP_NOP, SP_PUSH, SP_POP, SP_RST) and field-select constants.
- One sub-module, `stack_ctrl`: sp register, occupancy counter, full/empty decode, ovf/udf flags. It outputs the stack address and the write/read enables.
- The top holds the RAM array, MAR, output registers and arbitration.

## Test plan
- Directed scenarios use defaults (DATA_W=4, ADDR_W=4, STACK_DEPTH=4).
- MAR/field write: Laddr with addrIn=0001; WE Edata=0 ramIn=1010; WE Edata=1 ramIn=0111; Eram -> next cycle opcodeOut=1010, dataOut=0111, rdValid=1.
- Stack LIFO: push 1111, push 1110 -> sp=1101. Pop -> dataOut=1110. Pop -> dataOut=1111, sp=1111, rdValid pulses each time.
- Overflow: push 5 values -> 5th ignored, ovf=1, sp=1011. Pop 4 -> last dataOut equals the 1st pushed value.
- Underflow and SP reset: pop from empty -> udf=1, dataOut unchanged, rdValid=0. Push 0011 then SP reset -> sp=1111, udf still 1.
- Priority: Esp push together with WE/Eram -> only the push acts, no rdValid. Laddr with Eram in the same cycle -> read uses the old MAR.
- Reset mid-operation: rst together with push 1001 -> sp=1111, no RAM write, all outputs 0 next cycle.
